cond_flag_unit: RTL and testbench
=================================

# cond_flag_unit

Status-flag register and condition-line generator for the single-cycle CPU. Captures zero, carry, overflow and sign from the ALU under per-flag write enables and drives the nine branch-condition lines (unconditional, Z/NZ, C/NC, V/NV, S/NS) consumed by the branch-condition select. It also holds a small LIFO that saves and restores the flags across interrupt entry and return.

## Interface

Parameters:
- DEPTH, 4, number of flag-save stack entries (power of two, 2..16)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- alu_z, alu_c, alu_v, alu_s  in  1 each  ALU result flags for the current instruction
- flag_we  in  4  per-flag write mask, bit order {s, v, c, z} = [3:0]
- flag_push  in  1  save current flags to stack (interrupt entry)
- flag_pop  in  1  restore flags from stack (return from interrupt)
- err_clr  in  1  clears sticky stack_err
- iu, iz, inz, ic, inc, iv, inv, is, ins  out  1 each  condition lines
- flags  out  4  registered flags {s, v, c, z}
- stack_full, stack_empty  out  1 each  LIFO status
- stack_err  out  1  sticky overflow/underflow/conflict indicator

## Operation

- Flag register F = {s, v, c, z}; reset value 4'b0000.
- Per-flag update: F[i] <= alu flag i when flag_we[i] = 1; unmasked bits hold.
- Condition lines, combinational from F only (never from alu_* inputs): iu = 1; iz = z; inz = ~z; ic = c; inc = ~c; iv = v; inv = ~v; is = s; ins = ~s.
- Stack: DEPTH x 4 LIFO, count cnt in 0..DEPTH; reset cnt = 0, entries don't-care.
- Push (flag_push = 1, flag_pop = 0): if cnt < DEPTH, write pre-update F to entry cnt, cnt++. If cnt = DEPTH: no write, cnt unchanged, stack_err <= 1.
- Pop (flag_pop = 1, flag_push = 0): if cnt > 0, F <= entry cnt-1 (all four bits, flag_we ignored that cycle), cnt--. If cnt = 0: F follows flag_we normally, cnt unchanged, stack_err <= 1.
- Push and pop in the same cycle: neither performed, cnt unchanged, stack_err <= 1; F follows flag_we normally.
- Push with flag_we != 0 in the same cycle: stack receives old F, F takes the ALU update (both happen).
- stack_full = (cnt == DEPTH); stack_empty = (cnt == 0); both combinational from cnt.
- stack_err: set as above, cleared by err_clr; a set condition in the same cycle as err_clr wins (stays 1).
- Reset mid-operation: F, cnt, stack_err return to 0 immediately (asynchronous); stack contents are lost.

## Timing

- Flag update latency: ALU flags sampled at edge N are visible on condition lines after edge N. A branch in cycle N+1 sees the result of instruction N; no same-cycle bypass.
- Pop restore is visible after the same edge; push has no visible effect on F.
- All outputs are glitch-free functions of registers only. Reset values: iu = 1, iz = 0, inz = 1, ic = 0, inc = 1, iv = 0, inv = 1, is = 0, ins = 1, flags = 0, stack_empty = 1, stack_full = 0, stack_err = 0.
- No handshake; push/pop are single-cycle strobes. Holding a strobe high repeats the operation every cycle.

## Structure

- Shared package: flag bit indices (Z = 0, C = 1, V = 2, S = 3) and the 4-bit condition-select codes (U = 4'b0000, Z = 4'b1000, NZ = 4'b1001, C = 4'b1010, NC = 4'b1011, V = 4'b1100, NV = 4'b1101, S = 4'b1110, NS = 4'b1111). The branch-condition select imports the same codes.
- One sub-module: flag_stack (parameterised LIFO with push, pop, data in/out, cnt, full, empty, and error reporting). The top level holds F, the write-mask logic, the condition lines and the sticky error.

## Test plan

- Reset: assert rst mid-cycle -> flags = 0, inz = inc = inv = ins = 1, iu = 1, stack_empty = 1, stack_err = 0, all without waiting for a clock edge.
- Masked write: alu = {s,v,c,z} = 1111, flag_we = 4'b0101 -> flags = 0101, iz = 1, ic = 0, iv = 1, is = 0 next cycle.
- Push/update/pop: F = 1010, push with flag_we = 1111 and alu = 0101 -> F = 0101, cnt = 1. Pop -> F = 1010, stack_empty = 1.
- Overflow: DEPTH = 4, five pushes -> stack_full after the 4th push, stack_err = 1 after the 5th, cnt = 4. err_clr -> stack_err = 0.
- Underflow and conflict: pop at cnt = 0 with flag_we = 0001 and alu_z = 1 -> z = 1, stack_err = 1. Push and pop together at cnt = 2 -> cnt stays 2, stack_err = 1.
- err_clr together with a new overflow -> stack_err remains 1.

Source files
------------

// File: rtl/cond_flag_unit_pkg.sv
// Shared definitions for the status-flag unit and the branch-condition select:
// flag bit positions, condition-select codes and the stack error rule.
package cond_flag_unit_pkg;

  localparam int unsigned FLAG_W = 4;
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_S = 3;

  typedef logic [FLAG_W-1:0] flags_t;

  typedef enum logic [3:0] {
    COND_U  = 4'b0000,
    COND_Z  = 4'b1000,
    COND_NZ = 4'b1001,
    COND_C  = 4'b1010,
    COND_NC = 4'b1011,
    COND_V  = 4'b1100,
    COND_NV = 4'b1101,
    COND_S  = 4'b1110,
    COND_NS = 4'b1111
  } cond_sel_e;

  // A strobe pair is an error when both fire, or when the requested side cannot proceed.
  function automatic logic stack_error(input logic push, input logic pop,
                                       input logic full, input logic empty);
    logic err_s;
    err_s = (push & pop) | (push & ~pop & full) | (pop & ~push & empty);
    return err_s;
  endfunction

endpackage

// File: rtl/cond_flag_unit_flag_stack.sv
// Flag-save LIFO used across interrupt entry/return. Reports a per-cycle error
// strobe for overflow, underflow and simultaneous push/pop.
module cond_flag_unit_flag_stack
  import cond_flag_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  flags_t din,
  output flags_t dout,
  output logic   pop_ok,
  output logic   full,
  output logic   empty,
  output logic   err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  flags_t        mem_q [DEPTH];
  logic          push_ok;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == {CW{1'b0}});
  assign push_ok = push & ~pop & ~full;
  assign pop_ok  = pop & ~push & ~empty;
  assign err     = stack_error(push, pop, full, empty);
  assign wr_idx  = cnt_q[AW-1:0];
  assign rd_idx  = AW'(cnt_q - CW'(1));
  assign dout    = mem_q[rd_idx];

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop_ok) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Entries carry no reset: a cleared count makes their contents unreachable.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/cond_flag_unit.sv
// Status-flag register with per-flag write mask, flag-save stack, sticky stack
// error and the nine branch-condition lines derived from the registered flags.
module cond_flag_unit
  import cond_flag_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic       alu_s,
  input  logic [3:0] flag_we,
  input  logic       flag_push,
  input  logic       flag_pop,
  input  logic       err_clr,
  output logic       iu,
  output logic       iz,
  output logic       inz,
  output logic       ic,
  output logic       inc,
  output logic       iv,
  output logic       inv,
  output logic       is,
  output logic       ins,
  output logic [3:0] flags,
  output logic       stack_full,
  output logic       stack_empty,
  output logic       stack_err
);

  flags_t flags_q;
  flags_t flags_d;
  flags_t alu_vec;
  flags_t stk_dout;
  logic   stk_pop_ok;
  logic   stk_err;
  logic   err_q;
  logic   err_d;

  cond_flag_unit_flag_stack #(.DEPTH(DEPTH)) u_stack (
    .clk    (clk),
    .rst    (rst),
    .push   (flag_push),
    .pop    (flag_pop),
    .din    (flags_q),
    .dout   (stk_dout),
    .pop_ok (stk_pop_ok),
    .full   (stack_full),
    .empty  (stack_empty),
    .err    (stk_err)
  );

  always_comb begin
    alu_vec         = 4'b0000;
    alu_vec[FLAG_Z] = alu_z;
    alu_vec[FLAG_C] = alu_c;
    alu_vec[FLAG_V] = alu_v;
    alu_vec[FLAG_S] = alu_s;
  end

  // A successful restore overrides the ALU write mask for that cycle.
  always_comb begin
    flags_d = flags_q;
    if (stk_pop_ok) begin
      flags_d = stk_dout;
    end else begin
      flags_d = (flags_q & ~flag_we) | (alu_vec & flag_we);
    end
  end

  always_comb begin
    err_d = err_q;
    if (stk_err) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 4'b0000;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign flags     = flags_q;
  assign stack_err = err_q;
  assign iu        = 1'b1;
  assign iz        = flags_q[FLAG_Z];
  assign inz       = ~flags_q[FLAG_Z];
  assign ic        = flags_q[FLAG_C];
  assign inc       = ~flags_q[FLAG_C];
  assign iv        = flags_q[FLAG_V];
  assign inv       = ~flags_q[FLAG_V];
  assign is        = flags_q[FLAG_S];
  assign ins       = ~flags_q[FLAG_S];

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed bench for cond_flag_unit: masked writes, save/restore ordering,
// overflow/underflow/conflict errors and asynchronous reset.
module tb_cond_flag_unit;

  logic       clk;
  logic       rst;
  logic       alu_z, alu_c, alu_v, alu_s;
  logic [3:0] flag_we;
  logic       flag_push, flag_pop, err_clr;
  logic       iu, iz, inz, ic, inc, iv, inv, is, ins;
  logic [3:0] flags;
  logic       stack_full, stack_empty, stack_err;

  int checks = 0;
  int errors = 0;

  cond_flag_unit #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v), .alu_s(alu_s),
    .flag_we(flag_we), .flag_push(flag_push), .flag_pop(flag_pop), .err_clr(err_clr),
    .iu(iu), .iz(iz), .inz(inz), .ic(ic), .inc(inc), .iv(iv), .inv(inv), .is(is), .ins(ins),
    .flags(flags), .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // {iu, iz, inz, ic, inc, iv, inv, is, ins} expected from flags {s,v,c,z}
  function automatic logic [8:0] cond_of(input logic [3:0] f);
    return {1'b1, f[0], ~f[0], f[1], ~f[1], f[2], ~f[2], f[3], ~f[3]};
  endfunction

  task automatic drive(input logic [3:0] alu, input logic [3:0] we,
                       input logic push, input logic pop, input logic clr);
    {alu_s, alu_v, alu_c, alu_z} = alu;
    flag_we   = we;
    flag_push = push;
    flag_pop  = pop;
    err_clr   = clr;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  // Checks flags, condition lines and {full, empty, err} together.
  task automatic expect_state(input string tag, input logic [3:0] f, input logic [2:0] st);
    chk({tag, "_flags"}, {5'b00000, flags}, {5'b00000, f});
    chk({tag, "_cond"}, {iu, iz, inz, ic, inc, iv, inv, is, ins}, cond_of(f));
    chk({tag, "_stat"}, {6'b000000, stack_full, stack_empty, stack_err}, {6'b000000, st});
  endtask

  initial begin
    rst = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    #12;
    expect_state("reset", 4'b0000, 3'b010);
    chk("reset_lines", {iu, iz, inz, ic, inc, iv, inv, is, ins}, 9'b101010101);
    rst = 1'b0;
    #5;

    // Masked write: only z and v take the ALU value
    drive(4'b1111, 4'b0101, 1'b0, 1'b0, 1'b0);
    tick();
    expect_state("masked", 4'b0101, 3'b010);
    chk("masked_lines", {iz, ic, iv, is}, 9'b000001010);

    // Condition lines must not follow ALU inputs before the edge
    drive(4'b1010, 4'b1111, 1'b0, 1'b0, 1'b0);
    #2;
    chk("no_bypass", {5'b00000, flags}, 9'b000000101);
    tick();
    expect_state("load1010", 4'b1010, 3'b010);

    // Push with simultaneous update, then restore
    drive(4'b0101, 4'b1111, 1'b1, 1'b0, 1'b0);
    tick();
    expect_state("push_upd", 4'b0101, 3'b000);
    drive(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    tick();
    expect_state("pop_rest", 4'b1010, 3'b010);

    // Fill the stack with distinct saved values
    drive(4'b0001, 4'b1111, 1'b1, 1'b0, 1'b0); tick();
    expect_state("push1", 4'b0001, 3'b000);
    drive(4'b0010, 4'b1111, 1'b1, 1'b0, 1'b0); tick();
    expect_state("push2", 4'b0010, 3'b000);
    drive(4'b0100, 4'b1111, 1'b1, 1'b0, 1'b0); tick();
    expect_state("push3", 4'b0100, 3'b000);
    drive(4'b1000, 4'b1111, 1'b1, 1'b0, 1'b0); tick();
    expect_state("push4_full", 4'b1000, 3'b100);
    drive(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0); tick();
    expect_state("push5_ovf", 4'b1111, 3'b101);
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1); tick();
    expect_state("err_clr", 4'b1111, 3'b100);
    drive(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1); tick();
    expect_state("clr_vs_ovf", 4'b1111, 3'b101);
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1); tick();
    expect_state("err_clr2", 4'b1111, 3'b100);

    // Restores come back in LIFO order; write mask ignored on restore
    drive(4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0); tick();
    expect_state("pop4", 4'b0100, 3'b000);
    drive(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0); tick();
    expect_state("pop3", 4'b0010, 3'b000);

    // Conflict at cnt = 2: nothing moves
    drive(4'b1111, 4'b0000, 1'b1, 1'b1, 1'b0); tick();
    expect_state("conflict", 4'b0010, 3'b001);
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1); tick();
    expect_state("conf_clr", 4'b0010, 3'b000);
    drive(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0); tick();
    expect_state("pop2", 4'b0001, 3'b000);
    drive(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0); tick();
    expect_state("pop1", 4'b1010, 3'b010);

    // Underflow: write mask still applies
    drive(4'b0001, 4'b0001, 1'b0, 1'b1, 1'b0); tick();
    expect_state("underflow", 4'b1011, 3'b011);

    // Asynchronous reset mid-cycle with a non-empty stack
    drive(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0); tick();
    expect_state("pre_rst", 4'b1011, 3'b001);
    #2;
    rst = 1'b1;
    #1;
    expect_state("async_rst", 4'b0000, 3'b010);
    #1;
    rst = 1'b0;
    tick();
    expect_state("post_rst", 4'b0000, 3'b010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
